// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave serial front end: FSM encodings,
// opcode constants and default word widths.
package spi_pkg;

  localparam int unsigned RX_W_DEF = 10;
  localparam int unsigned TX_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  // Sub-phase shared by the three data states.
  typedef enum logic [1:0] {
    PH_SHIFT = 2'd0,
    PH_WAIT  = 2'd1,
    PH_TX    = 2'd2,
    PH_DONE  = 2'd3
  } phase_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  function automatic logic [1:0] opcode_of(input logic [RX_W_DEF-1:0] word);
    return word[RX_W_DEF-1 -: 2];
  endfunction

endpackage

// File: rtl/spi_slave_if_if.sv
// RAM-side bus of the SPI front end: command words out, read data back in.
interface spi_slave_if_if
  import spi_pkg::*;
#(
  parameter int unsigned RX_W = RX_W_DEF,
  parameter int unsigned TX_W = TX_W_DEF
);

  logic [RX_W-1:0] rx_data;
  logic            rx_valid;
  logic [TX_W-1:0] tx_data;
  logic            tx_valid;

  modport master (
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/spi_slave_if.sv
// SPI slave serial front end: deserialises MOSI into command words for the
// RAM and serialises RAM read data onto MISO. Clocked by the SPI clock.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned RX_W = RX_W_DEF,
  parameter int unsigned TX_W = TX_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  spi_slave_if_if.master ram
);

  localparam int unsigned MAX_W = (RX_W > TX_W) ? RX_W : TX_W;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(RX_W - 1);
  localparam logic [CNT_W-1:0] TX_END  = CNT_W'(TX_W);

  state_e          state_q;
  phase_e          phase_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RX_W-2:0] rx_sh_q;
  logic [TX_W-1:0] tx_sh_q;
  logic [RX_W-1:0] rx_data_q;
  logic            rx_valid_q;
  logic            miso_q;
  logic            rd_addr_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      phase_q        <= PH_SHIFT;
      cnt_q          <= '0;
      rx_sh_q        <= '0;
      tx_sh_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_done_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (state_q != IDLE && SS_n) begin
        // Abort: partial frame is dropped, rx_data and rd_addr_done kept.
        state_q <= IDLE;
        phase_q <= PH_SHIFT;
        cnt_q   <= '0;
        miso_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!SS_n) state_q <= CHK_CMD;
          end
          CHK_CMD: begin
            phase_q <= PH_SHIFT;
            cnt_q   <= '0;
            if (!MOSI)               state_q <= WRITE;
            else if (rd_addr_done_q) state_q <= READ_DATA;
            else                     state_q <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            case (phase_q)
              PH_SHIFT: begin
                rx_sh_q <= {rx_sh_q[RX_W-3:0], MOSI};
                if (cnt_q == LAST_RX) begin
                  rx_data_q  <= {rx_sh_q, MOSI};
                  rx_valid_q <= 1'b1;
                  cnt_q      <= '0;
                  phase_q    <= (state_q == READ_DATA) ? PH_WAIT : PH_DONE;
                  if (state_q == READ_ADD) rd_addr_done_q <= 1'b1;
                end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
              end
              PH_WAIT: begin
                if (ram.tx_valid) begin
                  tx_sh_q <= ram.tx_data;
                  cnt_q   <= '0;
                  phase_q <= PH_TX;
                end
              end
              PH_TX: begin
                // One extra count after bit 0 returns MISO low and ends the read.
                if (cnt_q == TX_END) begin
                  miso_q         <= 1'b0;
                  rd_addr_done_q <= 1'b0;
                  cnt_q          <= '0;
                  phase_q        <= PH_DONE;
                end else begin
                  miso_q  <= tx_sh_q[TX_W-1];
                  tx_sh_q <= {tx_sh_q[TX_W-2:0], 1'b0};
                  cnt_q   <= cnt_q + CNT_W'(1);
                end
              end
              default: ;
            endcase
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign MISO         = miso_q;
  assign ram.rx_data  = rx_data_q;
  assign ram.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed self-checking bench for the SPI slave front end.
module tb_spi_slave_if;
  import spi_pkg::*;

  logic clk;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic MISO;

  int checks;
  int errors;
  int pulses;

  spi_slave_if_if #(.RX_W(10), .TX_W(8)) bus ();

  spi_slave_if #(.RX_W(10), .TX_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO),
    .ram  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles in which rx_valid was high.
  always @(posedge clk) if (bus.rx_valid === 1'b1) pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    MOSI = b;
    @(negedge clk);
  endtask

  task automatic start_frame(input logic dir);
    SS_n = 1'b0;
    @(negedge clk);
    MOSI = dir;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    @(negedge clk);
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b need 0", MISO); end
    checks++; if (bus.rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data got %h need 000", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b need 0", bus.rx_valid); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d need 0", dut.state_q); end
    checks++; if (dut.rd_addr_done_q !== 1'b0) begin errors++; $display("FAIL reset_rd_addr_done got %b need 0", dut.rd_addr_done_q); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_addr();
    int p0;
    p0 = pulses;
    start_frame(1'b0);
    checks++; if (dut.state_q !== WRITE) begin errors++; $display("FAIL wa_state got %0d need 2", dut.state_q); end
    for (int i = 9; i >= 0; i--) begin
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL wa_early_valid bit %0d got %b need 0", i, bus.rx_valid); end
      send_bit(OP_WR_ADDR[0] ? 1'b1 : ((10'h03A >> i) & 10'h1) != 0);
    end
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL wa_valid got %b need 1", bus.rx_valid); end
    checks++; if (bus.rx_data !== 10'h03A) begin errors++; $display("FAIL wa_data got %h need 03a", bus.rx_data); end
    @(negedge clk);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL wa_valid_drop got %b need 0", bus.rx_valid); end
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL wa_miso got %b need 0", MISO); end
    end_frame();
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL wa_idle got %0d need 0", dut.state_q); end
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL wa_pulse_count got %0d need 1", pulses - p0); end
  endtask

  task automatic test_write_data();
    int p0;
    p0 = pulses;
    start_frame(1'b0);
    send_word(10'h1A5);
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL wd_valid got %b need 1", bus.rx_valid); end
    checks++; if (bus.rx_data !== 10'h1A5) begin errors++; $display("FAIL wd_data got %h need 1a5", bus.rx_data); end
    checks++; if (bus.rx_data[9:8] !== OP_WR_DATA) begin errors++; $display("FAIL wd_opcode got %b need 01", bus.rx_data[9:8]); end
    @(negedge clk);
    end_frame();
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL wd_pulse_count got %0d need 1", pulses - p0); end
    checks++; if (dut.rd_addr_done_q !== 1'b0) begin errors++; $display("FAIL wd_rd_addr_done got %b need 0", dut.rd_addr_done_q); end
  endtask

  task automatic test_read_sequence();
    logic [7:0] exp_byte;
    exp_byte = 8'hA5;
    start_frame(1'b1);
    checks++; if (dut.state_q !== READ_ADD) begin errors++; $display("FAIL ra_state got %0d need 3", dut.state_q); end
    send_word(10'h23A);
    checks++; if (bus.rx_data !== 10'h23A) begin errors++; $display("FAIL ra_data got %h need 23a", bus.rx_data); end
    checks++; if (dut.rd_addr_done_q !== 1'b1) begin errors++; $display("FAIL ra_done got %b need 1", dut.rd_addr_done_q); end
    end_frame();

    start_frame(1'b1);
    checks++; if (dut.state_q !== READ_DATA) begin errors++; $display("FAIL rd_state got %0d need 4", dut.state_q); end
    send_word(10'h300);
    checks++; if (bus.rx_data !== 10'h300 || bus.rx_valid !== 1'b1) begin errors++; $display("FAIL rd_data got %h/%b need 300/1", bus.rx_data, bus.rx_valid); end
    @(negedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b1; bus.tx_data = exp_byte;
    @(negedge clk);
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL rd_capture_miso got %b need 0", MISO); end
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      checks++; if (MISO !== exp_byte[i]) begin errors++; $display("FAIL rd_miso_bit%0d got %b need %b", i, MISO, exp_byte[i]); end
    end
    @(negedge clk);
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL rd_miso_after got %b need 0", MISO); end
    checks++; if (dut.rd_addr_done_q !== 1'b0) begin errors++; $display("FAIL rd_done_clear got %b need 0", dut.rd_addr_done_q); end
    end_frame();
  endtask

  task automatic test_read_no_addr();
    logic [9:0] w;
    w = 10'h355;
    bus.tx_valid = 1'b1; bus.tx_data = 8'hFF;
    start_frame(1'b1);
    checks++; if (dut.state_q !== READ_ADD) begin errors++; $display("FAIL rn_state got %0d need 3", dut.state_q); end
    for (int i = 9; i >= 0; i--) send_bit(w[i]);
    checks++; if (bus.rx_data !== 10'h355) begin errors++; $display("FAIL rn_data got %h need 355", bus.rx_data); end
    for (int i = 0; i < 12; i++) begin
      checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL rn_miso cycle %0d got %b need 0", i, MISO); end
      @(negedge clk);
    end
    checks++; if (dut.state_q !== READ_ADD) begin errors++; $display("FAIL rn_state_hold got %0d need 3", dut.state_q); end
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    end_frame();
  endtask

  task automatic test_abort();
    int p0;
    logic [9:0] w;
    p0 = pulses;
    w = 10'h0C3;
    start_frame(1'b0);
    for (int i = 9; i >= 5; i--) send_bit(w[i]);
    SS_n = 1'b1;
    @(negedge clk);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL ab_idle got %0d need 0", dut.state_q); end
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL ab_no_pulse got %0d need 0", pulses - p0); end
    checks++; if (bus.rx_data !== 10'h355) begin errors++; $display("FAIL ab_data_hold got %h need 355", bus.rx_data); end
    checks++; if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL ab_cnt got %0d need 0", dut.cnt_q); end
    checks++; if (dut.rd_addr_done_q !== 1'b1) begin errors++; $display("FAIL ab_done_hold got %b need 1", dut.rd_addr_done_q); end
    start_frame(1'b0);
    send_word(w);
    checks++; if (bus.rx_data !== 10'h0C3 || bus.rx_valid !== 1'b1) begin errors++; $display("FAIL ab_next_frame got %h/%b need 0c3/1", bus.rx_data, bus.rx_valid); end
    end_frame();
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] b;
    b = 8'h5A;
    start_frame(1'b1);
    checks++; if (dut.state_q !== READ_DATA) begin errors++; $display("FAIL rt_state got %0d need 4", dut.state_q); end
    send_word(10'h300);
    bus.tx_valid = 1'b1; bus.tx_data = b;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    for (int i = 7; i >= 3; i--) @(negedge clk);
    checks++; if (MISO !== b[3]) begin errors++; $display("FAIL rt_bit3 got %b need %b", MISO, b[3]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL rt_miso got %b need 0", MISO); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rt_valid got %b need 0", bus.rx_valid); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rt_state_idle got %0d need 0", dut.state_q); end
    checks++; if (dut.rd_addr_done_q !== 1'b0) begin errors++; $display("FAIL rt_done got %b need 0", dut.rd_addr_done_q); end
    SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    test_reset();
    test_write_addr();
    test_write_data();
    test_read_sequence();
    test_read_no_addr();
    test_abort();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
